cmp_flag_monitor: RTL

- Sequential stage directly downstream of the 4-bit magnitude comparator.
- Consumes the comparator's equal/greater/less flags once per valid sample.
- Debounces them into qualified above-threshold and below-threshold alarms.
- Keeps a saturating count of equal samples and reports illegal flag combinations.

---
 rtl/cmp_flag_monitor.sv | 107 ++++++++++
 1 files changed

// File: rtl/cmp_flag_monitor.sv
// Debounces comparator e/g/l flags into qualified hi/lo alarms, counts equal samples.
// Optional CMP_FLAG_STICKY_ALARM_EN: alarms latch until clear or reset.
module cmp_flag_monitor #(
    parameter int HOLD_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             e,
    input  logic             g,
    input  logic             l,
    input  logic             clear,
    output logic             alarm_hi,
    output logic             alarm_lo,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [3:0]       run_len,
    output logic             flag_err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HI_PEND  = 3'd1,
        HI_ALARM = 3'd2,
        LO_PEND  = 3'd3,
        LO_ALARM = 3'd4
    } state_t;

    localparam logic [3:0]       HOLD   = 4'(HOLD_CNT);
    localparam logic [CNT_W-1:0] EQ_MAX = '1;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       run_len_d;
    logic [CNT_W-1:0] eq_cnt_d;
    logic             one_hot;
    logic             accept;
    logic             hi_run;
    logic             lo_run;

    // Exactly one of three flags: odd parity and not all three.
    assign one_hot = (e ^ g ^ l) & ~(e & g & l);
    assign accept  = in_valid & one_hot;
    assign hi_run  = (state_q == HI_PEND) || (state_q == HI_ALARM);
    assign lo_run  = (state_q == LO_PEND) || (state_q == LO_ALARM);

    always_comb begin
        state_d   = state_q;
        run_len_d = run_len;
        eq_cnt_d  = eq_cnt;
        if (accept) begin
            if (e) begin
                state_d   = IDLE;
                run_len_d = 4'd0;
                if (eq_cnt != EQ_MAX) begin
                    eq_cnt_d = eq_cnt + 1'b1;
                end
            end else if (g) begin
                // A continuing run grows up to HOLD; any other state restarts at 1.
                if (hi_run) begin
                    run_len_d = (run_len == HOLD) ? HOLD : run_len + 4'd1;
                end else begin
                    run_len_d = 4'd1;
                end
                state_d = (run_len_d == HOLD) ? HI_ALARM : HI_PEND;
            end else begin
                if (lo_run) begin
                    run_len_d = (run_len == HOLD) ? HOLD : run_len + 4'd1;
                end else begin
                    run_len_d = 4'd1;
                end
                state_d = (run_len_d == HOLD) ? LO_ALARM : LO_PEND;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            run_len  <= 4'd0;
            eq_cnt   <= '0;
            flag_err <= 1'b0;
            alarm_hi <= 1'b0;
            alarm_lo <= 1'b0;
        end else if (clear) begin
            state_q  <= IDLE;
            run_len  <= 4'd0;
            eq_cnt   <= '0;
            flag_err <= 1'b0;
            alarm_hi <= 1'b0;
            alarm_lo <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_len  <= run_len_d;
            eq_cnt   <= eq_cnt_d;
            flag_err <= in_valid & ~one_hot;
`ifdef CMP_FLAG_STICKY_ALARM_EN
            alarm_hi <= alarm_hi | (state_d == HI_ALARM);
            alarm_lo <= alarm_lo | (state_d == LO_ALARM);
`else
            alarm_hi <= (state_d == HI_ALARM);
            alarm_lo <= (state_d == LO_ALARM);
`endif
        end
    end

endmodule
